output_frame_scheduler: RTL and testbench

//  Sequences the MCU output path and paces sensor acquisition. Every dt period it

---
 rtl/output_frame_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_output_frame_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_frame_scheduler.sv
// Output frame scheduler: paces sensor sample ticks and loads roll/pitch/yaw into the MCU in turn.
// Latency: load strobe 1 cycle after angles_valid_in or done_in; frame_done_out 1 cycle after the yaw done.
// Backpressure: each axis waits for done_in (bounded by DONE_TIMEOUT); angles arriving mid-frame are dropped and flagged.
module output_frame_scheduler #(
    parameter int TICK_DIV     = 1000,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       configured_in,
    input  logic [7:0] dt_in,
    input  logic       angles_valid_in,
    input  logic       done_in,
    input  logic       clr_err_in,
    output logic       write_enable_out,
    output logic [1:0] output_select_out,
    output logic       sample_tick_out,
    output logic       busy_out,
    output logic       frame_done_out,
    output logic       overrun_out,
    output logic       timeout_out
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int WW = $clog2(DONE_TIMEOUT);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(DONE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        LOAD      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    axis_q, axis_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    dtc_q, dtc_d;
    logic [7:0]    dtl_q, dtl_d;
    logic          we_q, we_d;
    logic [1:0]    sel_q, sel_d;
    logic          tick_q, tick_d;
    logic          busy_q, busy_d;
    logic          fdone_q, fdone_d;
    logic          ovr_q, ovr_d;
    logic          tmo_q, tmo_d;
    logic          ovr_set, tmo_set;
    logic          presc_wrap;

    // Frame sequencing: next state, axis/wait counters and the registered strobe outputs.
    always_comb begin
        state_d = state_q;
        axis_d  = axis_q;
        wait_d  = wait_q;
        fdone_d = 1'b0;
        ovr_set = 1'b0;
        tmo_set = 1'b0;
        case (state_q)
            IDLE: begin
                ovr_set = angles_valid_in;
                if (configured_in) state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (angles_valid_in) begin
                    state_d = LOAD;
                    axis_d  = 2'd0;
                end
            end
            LOAD: begin
                ovr_set = angles_valid_in;
                wait_d  = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                ovr_set = angles_valid_in;
                if (done_in) begin
                    if (axis_q < 2'd2) begin
                        axis_d  = axis_q + 2'd1;
                        state_d = LOAD;
                    end else begin
                        axis_d  = 2'd0;
                        fdone_d = 1'b1;
                        state_d = WAIT_DATA;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    // Missing done: abandon the rest of the frame.
                    tmo_set = 1'b1;
                    axis_d  = 2'd0;
                    state_d = WAIT_DATA;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Losing configuration aborts whatever is in flight.
        if (!configured_in) begin
            state_d = IDLE;
            axis_d  = 2'd0;
            wait_d  = '0;
            fdone_d = 1'b0;
        end
        we_d   = (state_d == LOAD);
        busy_d = (state_d == LOAD) || (state_d == WAIT_DONE);
        sel_d  = busy_d ? axis_d : 2'd0;
        // A new error event outranks a simultaneous clear.
        ovr_d  = ovr_set | (ovr_q & ~clr_err_in);
        tmo_d  = tmo_set | (tmo_q & ~clr_err_in);
    end

    assign presc_wrap = (presc_q == PRESC_LAST);

    // Sample pacing: prescaler wraps advance a dt counter; the period reloads only at tick boundaries.
    always_comb begin
        presc_d = presc_q;
        dtc_d   = dtc_q;
        dtl_d   = dtl_q;
        tick_d  = 1'b0;
        if (!configured_in) begin
            presc_d = '0;
            dtc_d   = 8'd0;
        end else if (state_q == IDLE) begin
            presc_d = '0;
            dtc_d   = 8'd0;
            dtl_d   = dt_in;
        end else begin
            presc_d = presc_wrap ? '0 : presc_q + PW'(1);
            if (presc_wrap) begin
                if (dtl_q == 8'd0) begin
                    // Pacing disabled: keep polling dt_in each wrap.
                    dtl_d = dt_in;
                end else if (dtc_q == dtl_q - 8'd1) begin
                    tick_d = 1'b1;
                    dtc_d  = 8'd0;
                    dtl_d  = dt_in;
                end else begin
                    dtc_d = dtc_q + 8'd1;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            axis_q  <= 2'd0;
            wait_q  <= '0;
            presc_q <= '0;
            dtc_q   <= 8'd0;
            dtl_q   <= 8'd0;
            we_q    <= 1'b0;
            sel_q   <= 2'd0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            fdone_q <= 1'b0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            axis_q  <= axis_d;
            wait_q  <= wait_d;
            presc_q <= presc_d;
            dtc_q   <= dtc_d;
            dtl_q   <= dtl_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
            fdone_q <= fdone_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign write_enable_out  = we_q;
    assign output_select_out = sel_q;
    assign sample_tick_out   = tick_q;
    assign busy_out          = busy_q;
    assign frame_done_out    = fdone_q;
    assign overrun_out       = ovr_q;
    assign timeout_out       = tmo_q;

endmodule

// File: tb/tb_output_frame_scheduler.sv
// Bench for output_frame_scheduler: directed frame/timeout/overrun/config steps plus randomized
// done delays and dt changes; sample ticks are predicted from a period-arithmetic model.
// Outputs are sampled 1 time unit after each rising edge.
module tb_output_frame_scheduler;
    localparam int TD = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       configured_in;
    logic [7:0] dt_in;
    logic       angles_valid_in;
    logic       done_in;
    logic       clr_err_in;
    logic       write_enable_out;
    logic [1:0] output_select_out;
    logic       sample_tick_out;
    logic       busy_out;
    logic       frame_done_out;
    logic       overrun_out;
    logic       timeout_out;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    // Pacing reference: m_B is the first cycle of the current period, m_dtl its length in TD units.
    bit m_idle = 1'b1;
    bit m_on   = 1'b0;
    int m_B    = 0;
    int m_dtl  = 0;
    bit rnd_dt = 1'b0;
    int tick_times[$];
    int t0, t1;

    output_frame_scheduler #(.TICK_DIV(TD), .DONE_TIMEOUT(TO)) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .configured_in     (configured_in),
        .dt_in             (dt_in),
        .angles_valid_in   (angles_valid_in),
        .done_in           (done_in),
        .clr_err_in        (clr_err_in),
        .write_enable_out  (write_enable_out),
        .output_select_out (output_select_out),
        .sample_tick_out   (sample_tick_out),
        .busy_out          (busy_out),
        .frame_done_out    (frame_done_out),
        .overrun_out       (overrun_out),
        .timeout_out       (timeout_out)
    );

    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle; predict and check sample_tick_out for the new cycle.
    task automatic tick();
        bit nxt;
        nxt = 1'b0;
        if (rnd_dt && $urandom_range(0, 7) == 0) dt_in = 8'($urandom_range(0, 3));
        if (!n_rst || !configured_in) begin
            m_idle = 1'b1;
            m_on   = 1'b0;
        end else if (m_idle) begin
            m_idle = 1'b0;
            m_on   = 1'b1;
            m_B    = cyc + 1;
            m_dtl  = int'(dt_in);
        end else if (m_on) begin
            if (m_dtl == 0) begin
                if (cyc == m_B + TD - 1) begin
                    m_B   = cyc + 1;
                    m_dtl = int'(dt_in);
                end
            end else if (cyc == m_B + m_dtl * TD - 1) begin
                m_B   = cyc + 1;
                m_dtl = int'(dt_in);
                nxt   = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk_b("sample_tick", sample_tick_out, nxt);
        if (sample_tick_out) tick_times.push_back(cyc);
    endtask

    task automatic wait_tick(input int maxc, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!sample_tick_out && n < maxc);
        chk_b(tag, sample_tick_out, 1'b1);
    endtask

    // One full frame; d[a] cycles between strobe of axis a and its done_in.
    task automatic run_frame(input int d0, input int d1, input int d2,
                             input int ovr_axis, input bit with_clr);
        int d[3];
        d = '{d0, d1, d2};
        chk_b("pre_we", write_enable_out, 1'b0);
        chk_b("pre_busy", busy_out, 1'b0);
        angles_valid_in = 1'b1;
        tick();
        angles_valid_in = 1'b0;
        chk_b("strobe0_we", write_enable_out, 1'b1);
        chk_v("strobe0_sel", 32'(output_select_out), 32'd0);
        chk_b("strobe0_busy", busy_out, 1'b1);
        for (int a = 0; a < 3; a++) begin
            for (int k = 1; k <= d[a]; k++) begin
                if (a == ovr_axis && k == 2) begin
                    angles_valid_in = 1'b1;
                    clr_err_in      = with_clr;
                end
                tick();
                angles_valid_in = 1'b0;
                clr_err_in      = 1'b0;
                if (a == ovr_axis && k == 2) chk_b("overrun_mid", overrun_out, 1'b1);
                chk_b("hold_we", write_enable_out, 1'b0);
                chk_v("hold_sel", 32'(output_select_out), 32'(a));
                chk_b("hold_busy", busy_out, 1'b1);
            end
            done_in = 1'b1;
            tick();
            done_in = 1'b0;
            if (a < 2) begin
                chk_b("next_we", write_enable_out, 1'b1);
                chk_v("next_sel", 32'(output_select_out), 32'(a + 1));
                chk_b("next_fdone", frame_done_out, 1'b0);
            end else begin
                chk_b("fdone", frame_done_out, 1'b1);
                chk_b("fdone_we", write_enable_out, 1'b0);
                chk_b("fdone_busy", busy_out, 1'b0);
                chk_v("fdone_sel", 32'(output_select_out), 32'd0);
            end
        end
        tick();
        chk_b("fdone_pulse", frame_done_out, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0; configured_in = 1'b0; dt_in = 8'd0;
        angles_valid_in = 1'b0; done_in = 1'b0; clr_err_in = 1'b0;
        tick();
        tick();
        chk_b("rst_we", write_enable_out, 1'b0);
        chk_v("rst_sel", 32'(output_select_out), 32'd0);
        chk_b("rst_busy", busy_out, 1'b0);
        chk_b("rst_fdone", frame_done_out, 1'b0);
        chk_b("rst_ovr", overrun_out, 1'b0);
        chk_b("rst_tmo", timeout_out, 1'b0);
        n_rst = 1'b1;
        tick();

        // Unconfigured: angles are overruns, never loads.
        angles_valid_in = 1'b1;
        tick();
        angles_valid_in = 1'b0;
        chk_b("idle_ovr", overrun_out, 1'b1);
        chk_b("idle_we0", write_enable_out, 1'b0);
        chk_b("idle_busy", busy_out, 1'b0);
        repeat (3) begin
            angles_valid_in = 1'b1;
            tick();
            angles_valid_in = 1'b0;
            tick();
            chk_b("idle_we", write_enable_out, 1'b0);
        end
        clr_err_in = 1'b1;
        tick();
        clr_err_in = 1'b0;
        chk_b("ovr_clr", overrun_out, 1'b0);

        // Configure, then frames with fixed and random done delays.
        dt_in = 8'd3;
        configured_in = 1'b1;
        tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        chk_b("stray_done_we", write_enable_out, 1'b0);
        chk_b("stray_done_busy", busy_out, 1'b0);
        run_frame(5, 5, 5, -1, 1'b0);
        repeat (4) run_frame($urandom_range(1, 12), $urandom_range(1, 12),
                             $urandom_range(1, 12), -1, 1'b0);

        // Pacing: 12-cycle period, dt change mid-period, then dt=0.
        wait_tick(30, "tick_dt3");
        t0 = cyc;
        repeat (5) tick();
        dt_in = 8'd1;
        wait_tick(20, "tick_after_change");
        chk_v("gap_old_period", 32'(cyc - t0), 32'd12);
        t1 = cyc;
        wait_tick(10, "tick_dt1");
        chk_v("gap_dt1", 32'(cyc - t1), 32'd4);
        t1 = cyc;
        dt_in = 8'd0;
        wait_tick(10, "tick_last");
        chk_v("gap_last", 32'(cyc - t1), 32'd4);
        tick_times.delete();
        repeat (30) tick();
        chk_v("no_ticks_dt0", 32'(tick_times.size()), 32'd0);
        dt_in = 8'd2;
        wait_tick(20, "tick_resume");

        // Timeout on pitch, then a normal frame from roll.
        angles_valid_in = 1'b1;
        tick();
        angles_valid_in = 1'b0;
        chk_b("to_we0", write_enable_out, 1'b1);
        repeat (3) tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        chk_v("to_sel1", 32'(output_select_out), 32'd1);
        repeat (TO) tick();
        chk_b("to_not_yet", timeout_out, 1'b0);
        chk_b("to_busy_pre", busy_out, 1'b1);
        tick();
        chk_b("to_set", timeout_out, 1'b1);
        chk_b("to_busy", busy_out, 1'b0);
        chk_v("to_sel", 32'(output_select_out), 32'd0);
        chk_b("to_fdone", frame_done_out, 1'b0);
        run_frame(2, 3, 4, -1, 1'b0);
        chk_b("to_sticky", timeout_out, 1'b1);
        clr_err_in = 1'b1;
        tick();
        clr_err_in = 1'b0;
        chk_b("to_clr", timeout_out, 1'b0);

        // Overrun mid-frame; set beats simultaneous clear.
        run_frame(3, 5, 3, 1, 1'b0);
        chk_b("ovr_after_frame", overrun_out, 1'b1);
        run_frame(5, 3, 3, 0, 1'b1);
        chk_b("ovr_set_wins", overrun_out, 1'b1);
        clr_err_in = 1'b1;
        tick();
        clr_err_in = 1'b0;
        chk_b("ovr_clr2", overrun_out, 1'b0);

        // Random frames with random dt changes.
        rnd_dt = 1'b1;
        repeat (6) run_frame($urandom_range(1, 12), $urandom_range(1, 12),
                             $urandom_range(1, 12), -1, 1'b0);
        rnd_dt = 1'b0;

        // Configuration drop during roll wait.
        angles_valid_in = 1'b1;
        tick();
        angles_valid_in = 1'b0;
        chk_b("cfg_we", write_enable_out, 1'b1);
        tick();
        tick();
        configured_in = 1'b0;
        tick();
        chk_b("cfg_busy", busy_out, 1'b0);
        chk_b("cfg_we0", write_enable_out, 1'b0);
        chk_v("cfg_sel", 32'(output_select_out), 32'd0);
        repeat (8) begin
            done_in = 1'b1;
            tick();
            done_in = 1'b0;
            tick();
            chk_b("cfg_no_strobe", write_enable_out, 1'b0);
        end
        configured_in = 1'b1;
        dt_in = 8'd2;
        tick();
        t0 = cyc;
        wait_tick(20, "tick_reconf");
        chk_v("reconf_phase", 32'(cyc - t0), 32'd8);

        // Asynchronous reset mid-frame.
        angles_valid_in = 1'b1;
        tick();
        chk_b("ar_we", write_enable_out, 1'b1);
        tick();
        angles_valid_in = 1'b0;
        chk_b("ar_ovr", overrun_out, 1'b1);
        #2;
        n_rst  = 1'b0;
        m_idle = 1'b1;
        m_on   = 1'b0;
        #1;
        chk_b("ar_busy", busy_out, 1'b0);
        chk_b("ar_we0", write_enable_out, 1'b0);
        chk_v("ar_sel", 32'(output_select_out), 32'd0);
        chk_b("ar_ovr0", overrun_out, 1'b0);
        tick();
        n_rst = 1'b1;
        tick();
        tick();
        chk_b("ar_idle_busy", busy_out, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
